// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared sizes, requester indices and request record for the register-file write arbiter.
package rf_arb_pkg;
  localparam int NUM_REQ    = 3;
  localparam int AGE_LIMIT  = 4;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int REQ_LOAD   = 0;
  localparam int REQ_MULDIV = 1;
  localparam int REQ_ALU    = 2;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } req_t;
endpackage

// File: rtl/rf_arb_age_counter.sv
// rf_arb_age_counter: saturating wait counter for one requester, flagging it aged at the limit.
module rf_arb_age_counter import rf_arb_pkg::*; #(
  parameter int AGE_LIMIT = rf_arb_pkg::AGE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic valid,
  input  logic ready,
  output logic aged
);
  localparam int CW = $clog2(AGE_LIMIT + 1);
  logic [CW-1:0] count;
  always_ff @(posedge clk)
    if (reset || !valid || ready) count <= '0;
    else if (count != CW'(AGE_LIMIT)) count <= count + 1'b1;
  assign aged = !reset && count == CW'(AGE_LIMIT);
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: fixed-priority register-file write arbiter with age promotion and a one-cycle write stage.
module rf_write_arbiter import rf_arb_pkg::*; #(
  parameter int NUM_REQ   = rf_arb_pkg::NUM_REQ,
  parameter int AGE_LIMIT = rf_arb_pkg::AGE_LIMIT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                stall,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]      req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                write,
  output logic [REG_ADDR_W-1:0]               reg_write_address,
  output logic [DATA_W-1:0]                   write_data,
  output logic [NUM_REQ-1:0]                  aged
);
  logic [NUM_REQ-1:0] aged_valid, cand, grant;
  req_t sel;
  logic wr_next, wr_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  genvar g;
  for (g = 0; g < NUM_REQ; g++) begin : g_age
    rf_arb_age_counter #(.AGE_LIMIT(AGE_LIMIT)) u_age (
      .clk   (clk),
      .reset (reset),
      .valid (req_valid[g]),
      .ready (req_ready[g]),
      .aged  (aged[g])
    );
  end
  // Aged requesters form the candidate set when present; lowest set bit wins.
  assign aged_valid = aged & req_valid;
  assign cand       = |aged_valid ? aged_valid : req_valid;
  assign grant      = cand & (~cand + 1'b1);
  assign req_ready  = (reset || stall) ? '0 : grant;
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) sel = '{valid: 1'b1, addr: req_addr[i], data: req_data[i]};
  end
  assign wr_next = sel.valid && sel.addr != '0;
  always_ff @(posedge clk)
    if (reset) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wr_q <= wr_next;
      if (wr_next) begin
        addr_q <= sel.addr;
        data_q <= sel.data;
      end
    end
  // Masking with reset drops a write still pending in the stage when reset arrives.
  assign write             = wr_q && !reset;
  assign reg_write_address = reset ? '0 : addr_q;
  assign write_data        = reset ? '0 : data_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed scenarios plus random traffic checked against a behavioural arbiter model.
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;
  localparam int N   = 3;
  localparam int LIM = 4;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0][4:0] req_addr = '0;
  logic [N-1:0][31:0] req_data = '0;
  logic [N-1:0] req_ready, aged;
  logic write;
  logic [4:0] reg_write_address;
  logic [31:0] write_data;
  int tests = 0, fails = 0;
  int m_age [N];
  bit m_wr;
  bit [4:0] m_wa;
  bit [31:0] m_wd;
  bit [N-1:0] m_xfer, p_pend;
  bit [4:0] p_a [N];
  bit [31:0] p_d [N];
  bit chk_en = 1'b0;
  logic [31:0] rf [32] = '{default: '0};

  always #5 clk = ~clk;

  rf_write_arbiter #(.NUM_REQ(N), .AGE_LIMIT(LIM)) dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .req_valid         (req_valid),
    .req_addr          (req_addr),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .write             (write),
    .reg_write_address (reg_write_address),
    .write_data        (write_data),
    .aged              (aged)
  );

  // Register file environment commits on the falling edge.
  always @(negedge clk) if (write && reg_write_address != 0) rf[reg_write_address] <= write_data;

  function automatic int m_grant();
    if (reset || stall) return -1;
    for (int i = 0; i < N; i++) if (req_valid[i] && m_age[i] == LIM) return i;
    for (int i = 0; i < N; i++) if (req_valid[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int g;
    for (int i = 0; i < N; i++)
      if (p_pend[i] && (req_valid[i] !== 1'b1 || req_addr[i] !== p_a[i] || req_data[i] !== p_d[i])) begin
        fails++;
        $display("FAIL stability: requester %0d changed before transfer", i);
      end
    g = m_grant();
    m_xfer = '0;
    if (g >= 0) m_xfer[g] = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_age[i] = (reset || !req_valid[i] || m_xfer[i]) ? 0 : (m_age[i] < LIM ? m_age[i] + 1 : LIM);
      p_pend[i] = !reset && req_valid[i] && !m_xfer[i];
      p_a[i] = req_addr[i];
      p_d[i] = req_data[i];
    end
    if (reset) begin
      m_wr = 0; m_wa = '0; m_wd = '0;
    end else if (g >= 0 && req_addr[g] != 0) begin
      m_wr = 1; m_wa = req_addr[g]; m_wd = req_data[g];
    end else m_wr = 0;
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er, ea;
    #2;
    if (chk_en) begin
      g = m_grant();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      for (int i = 0; i < N; i++) ea[i] = !reset && m_age[i] == LIM;
      check("ready", req_ready, er);
      check("aged", aged, ea);
      check("write", write, !reset && m_wr);
      check("waddr", reg_write_address, reset ? 5'd0 : m_wa);
      check("wdata", write_data, reset ? 32'd0 : m_wd);
    end
  end

  task automatic rq(input int i, input bit v, input bit [4:0] a, input bit [31:0] d);
    req_valid[i] = v; req_addr[i] = a; req_data[i] = d;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    #3;
    check("rst_ready", req_ready, 0);
    check("rst_write", write, 0);
    check("rst_addr", reg_write_address, 0);
    check("rst_data", write_data, 0);
    check("rst_aged", aged, 0);
    // single ALU request
    @(negedge clk); reset = 0; rq(REQ_ALU, 1, 5, 32'hDEADBEEF); #3;
    check("single_ready", req_ready, 3'b100);
    @(negedge clk); rq(REQ_ALU, 0, 0, 0); #3;
    check("single_write", write, 1);
    check("single_addr", reg_write_address, 5);
    check("single_data", write_data, 32'hDEADBEEF);
    @(negedge clk); #3;
    check("single_rf5", rf[5], 32'hDEADBEEF);
    check("single_idle", write, 0);
    // contention LOAD vs ALU
    @(negedge clk); rq(REQ_LOAD, 1, 3, 32'h0000AAAA); rq(REQ_ALU, 1, 7, 32'h0000BBBB); #3;
    check("cont_ready0", req_ready, 3'b001);
    @(negedge clk); rq(REQ_LOAD, 0, 0, 0); #3;
    check("cont_ready2", req_ready, 3'b100);
    check("cont_w1", write, 1);
    check("cont_a1", reg_write_address, 3);
    @(negedge clk); rq(REQ_ALU, 0, 0, 0); #3;
    check("cont_w2", write, 1);
    check("cont_a2", reg_write_address, 7);
    check("cont_d2", write_data, 32'h0000BBBB);
    // aging: LOAD streams, ALU waits until aged
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rq(REQ_LOAD, 1, 10, 32'h100 + k);
      if (k == 0) rq(REQ_ALU, 1, 9, 32'hA9A9);
      #3;
      check("age_flag", aged, k < 4 ? 3'b000 : 3'b100);
      check("age_ready", req_ready, k < 4 ? 3'b001 : 3'b100);
    end
    @(negedge clk); rq(REQ_ALU, 0, 0, 0); #3;
    check("age_clear", aged, 0);
    check("age_load_back", req_ready, 3'b001);
    check("age_waddr", reg_write_address, 9);
    check("age_wdata", write_data, 32'hA9A9);
    @(negedge clk); rq(REQ_LOAD, 0, 0, 0);
    // zero register
    @(negedge clk); rq(REQ_MULDIV, 1, 0, 1); #3;
    check("zero_ready", req_ready, 3'b010);
    @(negedge clk); rq(REQ_MULDIV, 0, 0, 0); #3;
    check("zero_write", write, 0);
    check("zero_rf0", rf[0], 0);
    // stall then reset after a transfer
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); stall = 1;
      rq(REQ_LOAD, 1, 1, 32'h11); rq(REQ_MULDIV, 1, 2, 32'h22); rq(REQ_ALU, 1, 4, 32'h44); #3;
      check("stall_ready", req_ready, 0);
    end
    @(negedge clk); stall = 0; #3;
    check("unstall_ready", req_ready, 3'b001);
    check("unstall_aged", aged, 0);
    @(negedge clk); reset = 1; rq(REQ_LOAD, 0, 0, 0); #3;
    check("rstp_ready", req_ready, 0);
    check("rstp_write", write, 0);
    check("rstp_addr", reg_write_address, 0);
    check("rstp_data", write_data, 0);
    check("rstp_aged", aged, 0);
    @(negedge clk); reset = 0; #3;
    check("resume_write", write, 0);
    check("resume_ready", req_ready, 3'b010);
    // random traffic honouring the hold-until-transfer rule
    repeat (3000) begin
      @(negedge clk);
      reset = ($urandom % 50) == 0;
      stall = ($urandom % 5) == 0;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && m_xfer[i]) req_valid[i] = 0;
        if (!req_valid[i] && ($urandom % 2)) rq(i, 1, ($urandom % 4) == 0 ? 5'd0 : 5'($urandom), $urandom);
      end
    end
    @(negedge clk); chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
